// File: rtl/pb_hub_pkg.sv
// Shared constants for the KCPSM6 port-space hub: control-block offsets,
// interrupt FSM encoding and the priority-encoder helper.
package pb_hub_pkg;

  localparam logic [1:0] OFS_PEND = 2'd0;
  localparam logic [1:0] OFS_MASK = 2'd1;
  localparam logic [1:0] OFS_VEC  = 2'd2;
  localparam logic [1:0] OFS_ID   = 2'd3;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  localparam logic [7:0] SPURIOUS_VEC = 8'hFF;

  // Index of the lowest set bit, or SPURIOUS_VEC when no bit is set.
  function automatic logic [7:0] lowest_set(input logic [7:0] bits);
    logic [7:0] idx;
    idx = SPURIOUS_VEC;
    for (int k = 7; k >= 0; k--) begin
      if (bits[k]) idx = 8'(k);
    end
    return idx;
  endfunction

endpackage

// File: rtl/pb_irq_ctrl.sv
// Interrupt controller: rising-edge capture, pending/mask registers,
// lowest-index priority, request/acknowledge FSM and vector register.
module pb_irq_ctrl
  import pb_hub_pkg::*;
#(
  parameter int NUM_IRQ = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq_src,
  input  logic               pend_clr_we,
  input  logic               mask_we,
  input  logic [NUM_IRQ-1:0] wr_data,
  input  logic               ack,
  output logic [NUM_IRQ-1:0] pending,
  output logic [NUM_IRQ-1:0] mask,
  output logic [7:0]         vector,
  output logic               irq
);

  logic [NUM_IRQ-1:0] src_q;
  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] active;
  logic [NUM_IRQ-1:0] ack_clr;
  logic [NUM_IRQ-1:0] w1c_clr;
  logic [NUM_IRQ-1:0] pend_next;
  logic [7:0]         sel;
  logic               take_ack;
  logic [1:0]         state;
  logic [1:0]         state_next;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned, which would infer a latch.
    rise       = irq_src & ~src_q;
    active     = pending & mask;
    sel        = lowest_set(8'(active));
    // An ack outside HOLD is honoured even from IDLE so a stray ack reports the spurious vector.
    take_ack   = ack && (state != ST_HOLD);
    ack_clr    = '0;
    for (int k = 0; k < NUM_IRQ; k++) begin
      if (take_ack && sel == 8'(k)) ack_clr[k] = 1'b1;
    end
    w1c_clr    = pend_clr_we ? wr_data : '0;
    // A coincident edge wins over either clear source.
    pend_next  = (pending & ~(w1c_clr | ack_clr)) | rise;

    state_next = state;
    case (state)
      ST_IDLE: begin
        if (take_ack)        state_next = ST_HOLD;
        else if (|active)    state_next = ST_REQ;
      end
      ST_REQ: begin
        if (take_ack)        state_next = ST_HOLD;
        else if (!(|active)) state_next = ST_IDLE;
      end
      ST_HOLD: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      src_q   <= '0;
      pending <= '0;
      mask    <= '0;
      vector  <= SPURIOUS_VEC;
      state   <= ST_IDLE;
    end else begin
      src_q   <= irq_src;
      pending <= pend_next;
      if (mask_we)  mask   <= wr_data;
      if (take_ack) vector <= sel;
      state   <= state_next;
    end
  end

  assign irq = (state == ST_REQ);

endmodule

// File: rtl/pb_port_hub.sv
// KCPSM6 port-space hub: address decode, writable output bank, registered
// input-read mux and the interrupt controller behind a 4-entry control block.
module pb_port_hub
  import pb_hub_pkg::*;
#(
  parameter int          NUM_IRQ   = 4,
  parameter int          NUM_OUT   = 8,
  parameter int          NUM_IN    = 8,
  parameter logic [7:0]  CTRL_BASE = 8'h00,
  parameter logic [7:0]  OUT_BASE  = 8'h10,
  parameter logic [7:0]  IN_BASE   = 8'h20,
  parameter logic [7:0]  HWBUILD   = 8'h00
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [7:0]           pb_port_id,
  input  logic [7:0]           pb_out_port,
  input  logic                 pb_write_strobe,
  input  logic                 pb_k_write_strobe,
  input  logic                 pb_read_strobe,
  output logic [7:0]           pb_in_port,
  output logic                 pb_interrupt,
  input  logic                 pb_interrupt_ack,
  input  logic [NUM_IRQ-1:0]   irq_src,
  output logic [8*NUM_OUT-1:0] out_regs,
  output logic [NUM_OUT-1:0]   out_wr_pulse,
  input  logic [8*NUM_IN-1:0]  in_data,
  output logic [NUM_IN-1:0]    in_rd_pulse
);

  logic [7:0]         ctrl_ofs;
  logic [7:0]         out_ofs;
  logic [7:0]         in_ofs;
  logic               ctrl_hit;
  logic               out_hit;
  logic               in_hit;
  logic [NUM_OUT-1:0] out_we;
  logic [NUM_IN-1:0]  in_sel;
  logic [7:0]         rd_data;
  logic               pend_clr_we;
  logic               mask_we;
  logic [NUM_IRQ-1:0] pending;
  logic [NUM_IRQ-1:0] mask;
  logic [7:0]         vector;

  // Offsets wrap modulo 256, so one unsigned compare checks each window.
  always_comb begin
    ctrl_ofs = pb_port_id - CTRL_BASE;
    out_ofs  = pb_port_id - OUT_BASE;
    in_ofs   = pb_port_id - IN_BASE;
    ctrl_hit = (ctrl_ofs < 8'd4);
    out_hit  = !ctrl_hit && (out_ofs < 8'(NUM_OUT));
    in_hit   = !ctrl_hit && !out_hit && (in_ofs < 8'(NUM_IN));
  end

  always_comb begin
    out_we = '0;
    for (int i = 0; i < NUM_OUT; i++) begin
      if (pb_write_strobe && out_hit && out_ofs == 8'(i))         out_we[i] = 1'b1;
      if (pb_k_write_strobe && pb_port_id[3:0] == 4'(i))          out_we[i] = 1'b1;
    end
  end

  always_comb begin
    in_sel = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (in_hit && in_ofs == 8'(i)) in_sel[i] = 1'b1;
    end
  end

  always_comb begin
    rd_data = 8'h00;
    if (ctrl_hit) begin
      case (ctrl_ofs[1:0])
        OFS_PEND: rd_data = 8'(pending);
        OFS_MASK: rd_data = 8'(mask);
        OFS_VEC:  rd_data = vector;
        OFS_ID:   rd_data = HWBUILD;
        default:  rd_data = 8'h00;
      endcase
    end else if (out_hit) begin
      for (int i = 0; i < NUM_OUT; i++) begin
        if (out_ofs == 8'(i)) rd_data = out_regs[8*i +: 8];
      end
    end else if (in_hit) begin
      for (int i = 0; i < NUM_IN; i++) begin
        if (in_sel[i]) rd_data = in_data[8*i +: 8];
      end
    end
  end

  assign pend_clr_we = pb_write_strobe && ctrl_hit && (ctrl_ofs[1:0] == OFS_PEND);
  assign mask_we     = pb_write_strobe && ctrl_hit && (ctrl_ofs[1:0] == OFS_MASK);

  // NOTE: the output bank is reset like any other register because the kernel datapath consumes it directly.
  always_ff @(posedge clk) begin
    if (!reset) begin
      out_regs     <= '0;
      out_wr_pulse <= '0;
      in_rd_pulse  <= '0;
      pb_in_port   <= 8'h00;
    end else begin
      for (int i = 0; i < NUM_OUT; i++) begin
        if (out_we[i]) out_regs[8*i +: 8] <= pb_out_port;
      end
      out_wr_pulse <= out_we;
      in_rd_pulse  <= pb_read_strobe ? in_sel : '0;
      pb_in_port   <= rd_data;
    end
  end

  pb_irq_ctrl #(
    .NUM_IRQ (NUM_IRQ)
  ) u_irq (
    .clk         (clk),
    .reset       (reset),
    .irq_src     (irq_src),
    .pend_clr_we (pend_clr_we),
    .mask_we     (mask_we),
    .wr_data     (pb_out_port[NUM_IRQ-1:0]),
    .ack         (pb_interrupt_ack),
    .pending     (pending),
    .mask        (mask),
    .vector      (vector),
    .irq         (pb_interrupt)
  );

endmodule

// File: tb/tb_pb_port_hub.sv
// Self-checking bench for pb_port_hub: directed scenarios plus randomized
// traffic, compared each cycle against a cycle-level behavioural model.
module tb_pb_port_hub;

  localparam int NUM_IRQ = 4;
  localparam int NUM_OUT = 8;
  localparam int NUM_IN  = 8;
  localparam int CB      = 8'h00;
  localparam int OB      = 8'h10;
  localparam int IB      = 8'h20;
  localparam logic [7:0] HW = 8'h5C;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [7:0]           port_id;
  logic [7:0]           out_port;
  logic                 ws, kws, rs, ack;
  logic [NUM_IRQ-1:0]   irq_src;
  logic [8*NUM_IN-1:0]  in_data;
  logic [7:0]           pb_in_port;
  logic                 pb_interrupt;
  logic [8*NUM_OUT-1:0] out_regs;
  logic [NUM_OUT-1:0]   out_wr_pulse;
  logic [NUM_IN-1:0]    in_rd_pulse;

  int n_checks = 0;
  int n_fail   = 0;

  pb_port_hub #(
    .NUM_IRQ(NUM_IRQ), .NUM_OUT(NUM_OUT), .NUM_IN(NUM_IN),
    .CTRL_BASE(8'(CB)), .OUT_BASE(8'(OB)), .IN_BASE(8'(IB)), .HWBUILD(HW)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .pb_port_id        (port_id),
    .pb_out_port       (out_port),
    .pb_write_strobe   (ws),
    .pb_k_write_strobe (kws),
    .pb_read_strobe    (rs),
    .pb_in_port        (pb_in_port),
    .pb_interrupt      (pb_interrupt),
    .pb_interrupt_ack  (ack),
    .irq_src           (irq_src),
    .out_regs          (out_regs),
    .out_wr_pulse      (out_wr_pulse),
    .in_data           (in_data),
    .in_rd_pulse       (in_rd_pulse)
  );

  always #5 clk = ~clk;

  // Behavioural model state
  logic [7:0]         m_out [NUM_OUT];
  logic [NUM_OUT-1:0] m_wr;
  logic [NUM_IN-1:0]  m_rd;
  logic [7:0]         m_in_port;
  logic [NUM_IRQ-1:0] m_pend, m_mask, m_prev;
  logic [7:0]         m_vec;
  bit                 m_irq;
  bit                 m_cool;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock using the inputs presented this cycle.
  task automatic model_step();
    int p;
    int idx;
    logic [7:0] rdv;
    logic [NUM_IRQ-1:0] active, rise, clr;
    bit in_ctrl, in_out, in_in, acc;
    if (!reset) begin
      for (int i = 0; i < NUM_OUT; i++) m_out[i] = 8'h00;
      m_wr = '0; m_rd = '0; m_in_port = 8'h00;
      m_pend = '0; m_mask = '0; m_prev = '0; m_vec = 8'hFF;
      m_irq = 0; m_cool = 0;
      return;
    end
    p       = int'(port_id);
    in_ctrl = (p >= CB) && (p < CB + 4);
    in_out  = !in_ctrl && (p >= OB) && (p < OB + NUM_OUT);
    in_in   = !in_ctrl && !in_out && (p >= IB) && (p < IB + NUM_IN);

    rdv = 8'h00;
    if (in_ctrl) begin
      case (p - CB)
        0: rdv = 8'(m_pend);
        1: rdv = 8'(m_mask);
        2: rdv = m_vec;
        default: rdv = HW;
      endcase
    end else if (in_out) rdv = m_out[p - OB];
    else if (in_in)      rdv = in_data[8*(p - IB) +: 8];
    m_in_port = rdv;

    m_rd = '0;
    if (rs && in_in) m_rd[p - IB] = 1'b1;

    m_wr = '0;
    if (ws && in_out) begin
      m_out[p - OB] = out_port;
      m_wr[p - OB]  = 1'b1;
    end
    if (kws && int'(port_id[3:0]) < NUM_OUT) begin
      m_out[port_id[3:0]] = out_port;
      m_wr[port_id[3:0]]  = 1'b1;
    end

    active = m_pend & m_mask;
    rise   = irq_src & ~m_prev;
    acc    = ack && !m_cool;
    clr    = '0;
    if (acc) begin
      idx = -1;
      for (int k = NUM_IRQ - 1; k >= 0; k--) if (active[k]) idx = k;
      if (idx < 0) m_vec = 8'hFF;
      else begin
        m_vec    = 8'(idx);
        clr[idx] = 1'b1;
      end
    end
    if (ws && in_ctrl && p - CB == 0) clr = clr | out_port[NUM_IRQ-1:0];
    if (ws && in_ctrl && p - CB == 1) m_mask = out_port[NUM_IRQ-1:0];
    m_pend = (m_pend & ~clr) | rise;
    m_prev = irq_src;

    if (acc) begin
      m_irq = 0; m_cool = 1;
    end else if (m_cool) begin
      m_irq = 0; m_cool = 0;
    end else begin
      m_irq = (active != 0);
    end
  endtask

  task automatic compare();
    logic [8*NUM_OUT-1:0] e;
    for (int i = 0; i < NUM_OUT; i++) e[8*i +: 8] = m_out[i];
    check("out_regs",     64'(out_regs),     64'(e));
    check("out_wr_pulse", 64'(out_wr_pulse), 64'(m_wr));
    check("in_rd_pulse",  64'(in_rd_pulse),  64'(m_rd));
    check("pb_in_port",   64'(pb_in_port),   64'(m_in_port));
    check("pb_interrupt", 64'(pb_interrupt), 64'(m_irq));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare();
  endtask

  task automatic quiet();
    ws = 0; kws = 0; rs = 0; ack = 0;
  endtask

  task automatic wr(input logic [7:0] p, input logic [7:0] d);
    quiet(); port_id = p; out_port = d; ws = 1;
    tick();
    ws = 0;
  endtask

  task automatic rd(input logic [7:0] p);
    quiet(); port_id = p; rs = 1;
    tick();
    rs = 0;
  endtask

  initial begin
    reset = 0; port_id = 8'h00; out_port = 8'h00; irq_src = '0;
    in_data = 64'h8877_6655_4433_2211;
    quiet();

    tick(); tick();
    check("rst_in_port", 64'(pb_in_port), 64'h0);
    check("rst_irq",     64'(pb_interrupt), 64'h0);
    check("rst_out",     64'(out_regs), 64'h0);
    reset = 1;
    tick();

    // Write/readback of output reg 3
    wr(8'h13, 8'hA5);
    check("wr_reg3",   64'(out_regs), 64'h0000_0000_A500_0000);
    check("wr_pulse3", 64'(out_wr_pulse), 64'h08);
    rd(8'h13);
    check("wr_pulse_gone", 64'(out_wr_pulse), 64'h00);
    check("rdback_a5", 64'(pb_in_port), 64'hA5);

    // Input port read and ID register
    rd(8'h22);
    check("in_port2", 64'(pb_in_port), 64'h33);
    check("rd_pulse2", 64'(in_rd_pulse), 64'h04);
    rd(8'h03);
    check("id_reg", 64'(pb_in_port), 64'(HW));

    // OUTPUTK to out-of-range index 9
    quiet(); port_id = 8'h09; out_port = 8'h77; kws = 1;
    tick();
    kws = 0;
    check("k9_regs",  64'(out_regs), 64'h0000_0000_A500_0000);
    check("k9_pulse", 64'(out_wr_pulse), 64'h00);

    // OUTPUTK to index 1
    quiet(); port_id = 8'hE1; out_port = 8'h3C; kws = 1;
    tick();
    kws = 0;
    check("k1_pulse", 64'(out_wr_pulse), 64'h02);

    // Two simultaneous masked-in edges, priority and re-assert timing
    wr(8'h01, 8'h05);
    quiet(); port_id = 8'h30; irq_src = 4'b0101;
    tick();
    check("irq_n", 64'(pb_interrupt), 64'h0);
    tick();
    check("irq_n1", 64'(pb_interrupt), 64'h1);
    ack = 1; port_id = 8'h02;
    tick();
    ack = 0;
    check("irq_after_ack", 64'(pb_interrupt), 64'h0);
    tick();
    check("vec0", 64'(pb_in_port), 64'h00);
    check("irq_m1", 64'(pb_interrupt), 64'h0);
    port_id = 8'h00;
    tick();
    check("pend_04", 64'(pb_in_port), 64'h04);
    check("irq_m2", 64'(pb_interrupt), 64'h1);
    ack = 1;
    tick();
    ack = 0; port_id = 8'h02;
    tick();
    check("vec2", 64'(pb_in_port), 64'h02);
    irq_src = '0;
    tick();

    // Mask removed while requesting, then a stray ack
    wr(8'h01, 8'h02);
    irq_src = 4'b0010;
    tick(); tick();
    check("irq_src1", 64'(pb_interrupt), 64'h1);
    wr(8'h01, 8'h00);
    quiet(); port_id = 8'h30;
    tick();
    check("irq_masked_off", 64'(pb_interrupt), 64'h0);
    ack = 1;
    tick();
    ack = 0; port_id = 8'h02;
    tick();
    check("vec_spurious", 64'(pb_in_port), 64'hFF);
    port_id = 8'h00;
    tick();
    check("pend_kept", 64'(pb_in_port), 64'h02);
    wr(8'h00, 8'h02);
    irq_src = '0;
    tick();

    // W1C racing a fresh edge on the same bit
    irq_src = 4'b0001; tick();
    irq_src = 4'b0000; tick();
    quiet(); port_id = 8'h00; out_port = 8'h01; ws = 1; irq_src = 4'b0001;
    tick();
    ws = 0;
    tick();
    check("w1c_set_wins", 64'(pb_in_port), 64'h01);

    // Reset while requesting
    wr(8'h01, 8'h01);
    quiet(); port_id = 8'h30;
    tick(); tick();
    check("irq_before_rst", 64'(pb_interrupt), 64'h1);
    reset = 0;
    tick();
    check("rst_irq_drop", 64'(pb_interrupt), 64'h0);
    check("rst_out_zero", 64'(out_regs), 64'h0);
    check("rst_port_zero", 64'(pb_in_port), 64'h0);
    reset = 1;
    irq_src = '0;
    tick();

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      quiet();
      case ($urandom_range(0, 3))
        0: port_id = 8'($urandom_range(0, 3));
        1: port_id = 8'(OB + $urandom_range(0, 9));
        2: port_id = 8'(IB + $urandom_range(0, 9));
        default: port_id = 8'($urandom);
      endcase
      out_port = 8'($urandom);
      case ($urandom_range(0, 9))
        0, 1, 2: ws  = 1;
        3:       kws = 1;
        default: ;
      endcase
      rs      = ($urandom_range(0, 3) == 0);
      ack     = ($urandom_range(0, 7) == 0);
      for (int k = 0; k < NUM_IRQ; k++) begin
        if ($urandom_range(0, 6) == 0) irq_src[k] = ~irq_src[k];
      end
      in_data = {$urandom, $urandom};
      reset   = ($urandom_range(0, 199) != 0);
      tick();
    end
    reset = 1;
    quiet();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
